// File: rtl/kcore_write_back.sv
// k-core write-back stage: drains num_items (vid, core) updates per start token
// into word writes to memory and pulses done once every write response is back.
module kcore_write_back #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int CNT_WIDTH       = 32,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_empty_n,
    output logic                    start_read,
    input  logic [CNT_WIDTH-1:0]    num_items,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic                    upd_empty_n,
    output logic                    upd_read,
    input  logic [2*DATA_WIDTH-1:0] upd_dout,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_resp_valid,
    output logic                    idle,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    items_written
);

    // One extra bit so the counter can hold MAX_OUTSTANDING itself.
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   remaining;
    logic [ADDR_WIDTH-1:0]  base;
    logic [OUT_W-1:0]       outstanding;
    logic [OUT_W-1:0]       in_flight;
    logic                   wr_accept;
    logic [ADDR_WIDTH-1:0]  vid_addr;

    assign wr_accept = wr_valid & wr_ready;
    // The held request counts against the limit before it is accepted.
    assign in_flight = outstanding + OUT_W'(wr_valid);
    assign vid_addr  = ADDR_WIDTH'(upd_dout[2*DATA_WIDTH-1:DATA_WIDTH]);

    assign idle = (state == S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        start_read = 1'b0;
        upd_read   = 1'b0;
        case (state)
            S_IDLE: begin
                start_read = start_empty_n;
                if (start_empty_n) begin
                    state_next = (num_items != '0) ? S_RUN : S_FLUSH;
                end
            end
            S_RUN: begin
                upd_read = upd_empty_n && (remaining != '0) && (!wr_valid || wr_ready) &&
                           (in_flight < OUT_W'(MAX_OUTSTANDING));
                if (upd_read && remaining == CNT_WIDTH'(1)) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!wr_valid && outstanding == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the write datapath is reset too, so the port reads zero rather than X after reset.
            state         <= S_IDLE;
            remaining     <= '0;
            base          <= '0;
            outstanding   <= '0;
            wr_valid      <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            items_written <= '0;
        end else begin
            state <= state_next;

            if (start_read) begin
                remaining <= num_items;
                base      <= base_addr;
            end else if (upd_read) begin
                remaining <= remaining - CNT_WIDTH'(1);
            end

            // A pop in the acceptance cycle keeps wr_valid high with the new word.
            if (upd_read) begin
                wr_valid <= 1'b1;
                wr_addr  <= base + (vid_addr << 2);
                wr_data  <= upd_dout[DATA_WIDTH-1:0];
            end else if (wr_ready) begin
                wr_valid <= 1'b0;
            end

            // Saturate at zero so stray responses after a reset are ignored.
            if (wr_accept && !wr_resp_valid) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (wr_resp_valid && !wr_accept && outstanding != '0) begin
                outstanding <= outstanding - OUT_W'(1);
            end

            if (start_read) begin
                items_written <= '0;
            end else if (wr_accept) begin
                items_written <= items_written + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_kcore_write_back.sv
// Self-checking bench for kcore_write_back: FIFO/memory models drive the DUT and a
// transaction-level reference model predicts every output each cycle.
module tb_kcore_write_back;

    localparam int MAX_OUT = 16;

    typedef enum {P_IDLE, P_RUN, P_FLUSH, P_DONE} phase_t;
    typedef struct { int unsigned num; logic [31:0] base; } start_t;
    typedef struct { longint unsigned c; logic [31:0] addr; } wlog_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_empty_n = 1'b0;
    logic        start_read;
    logic [31:0] num_items = '0;
    logic [31:0] base_addr = '0;
    logic        upd_empty_n = 1'b0;
    logic        upd_read;
    logic [63:0] upd_dout = '0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_resp_valid = 1'b0;
    logic        idle;
    logic        done;
    logic [31:0] items_written;

    kcore_write_back #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(32), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .reset(reset),
        .start_empty_n(start_empty_n), .start_read(start_read),
        .num_items(num_items), .base_addr(base_addr),
        .upd_empty_n(upd_empty_n), .upd_read(upd_read), .upd_dout(upd_dout),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_resp_valid(wr_resp_valid),
        .idle(idle), .done(done), .items_written(items_written)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Environment: FIFO contents, memory responder, logs.
    start_t          start_q[$];
    logic [63:0]     upd_q[$];
    longint unsigned resp_q[$];
    wlog_t           acc_log[$];
    longint unsigned cyc = 0;
    longint unsigned done_cyc = 0;
    longint unsigned start_pop_cyc = 0;
    int              done_cnt = 0;
    int              n_pops = 0;

    int ready_mode   = 0;  // 0 always ready, 1 random, 2 never
    int resp_delay   = 2;
    bit resp_hold    = 1'b0;
    int resp_release = 0;
    bit upd_gaps     = 1'b0;
    bit stray_en     = 1'b0;

    // Reference model state.
    phase_t      ph = P_IDLE;
    longint      m_rem = 0;
    logic [31:0] m_base = '0;
    bit          m_pend = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    int          m_out = 0;
    int unsigned m_items = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] b, input logic [31:0] vid);
        return 32'((longint'(b) + 4 * longint'(vid)) % 64'h1_0000_0000);
    endfunction

    task automatic cycle();
        bit resp;
        bit acc;
        bit exp_upd;
        bit pend_b;
        int out_b;
        longint unsigned due;
        @(negedge clk);
        if (!reset && start_q.size() > 0) begin
            start_empty_n = 1'b1;
            num_items     = start_q[0].num;
            base_addr     = start_q[0].base;
        end else begin
            start_empty_n = 1'b0;
        end
        if (!reset && upd_q.size() > 0 && !(upd_gaps && $urandom_range(0, 3) == 0)) begin
            upd_empty_n = 1'b1;
            upd_dout    = upd_q[0];
        end else begin
            upd_empty_n = 1'b0;
        end
        case (ready_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = ($urandom_range(0, 9) < 7);
            default: wr_ready = 1'b0;
        endcase
        if (reset) wr_ready = 1'b0;
        resp = 1'b0;
        if (resp_q.size() > 0 && resp_q[0] <= cyc && (!resp_hold || resp_release > 0)) begin
            resp = 1'b1;
            void'(resp_q.pop_front());
            if (resp_hold) resp_release--;
        end else if (stray_en && resp_q.size() == 0 && $urandom_range(0, 3) == 0) begin
            resp = 1'b1;
        end
        wr_resp_valid = resp;
        #1;

        exp_upd = (ph == P_RUN) && upd_empty_n && (m_rem != 0) && (!m_pend || wr_ready) &&
                  (m_out + int'(m_pend) < MAX_OUT);
        if (!reset) begin
            check("idle", idle, ph == P_IDLE);
            check("done", done, ph == P_DONE);
            check("start_read", start_read, (ph == P_IDLE) && start_empty_n);
            check("upd_read", upd_read, exp_upd);
            check("wr_valid", wr_valid, m_pend);
            check("wr_addr", wr_addr, m_addr);
            check("wr_data", wr_data, m_data);
            check("items_written", items_written, m_items);

            if (wr_valid && wr_ready) begin
                due = cyc + longint'(resp_delay);
                if (resp_q.size() > 0 && due < resp_q[$]) due = resp_q[$];
                resp_q.push_back(due);
                acc_log.push_back('{cyc, wr_addr});
            end
            if (upd_read && upd_empty_n) begin
                void'(upd_q.pop_front());
                n_pops++;
            end
            if (start_read && start_empty_n) begin
                void'(start_q.pop_front());
                start_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end

        if (reset) begin
            ph = P_IDLE; m_rem = 0; m_pend = 1'b0; m_out = 0; m_items = 0;
            m_addr = '0; m_data = '0; m_base = '0;
        end else begin
            pend_b = m_pend;
            out_b  = m_out;
            acc    = m_pend && wr_ready;
            if (acc && !resp) m_out++;
            else if (resp && !acc && m_out > 0) m_out--;
            if (acc) m_items++;
            if (exp_upd) begin
                m_pend = 1'b1;
                m_addr = exp_addr(m_base, upd_dout[63:32]);
                m_data = upd_dout[31:0];
                m_rem--;
            end else if (acc) begin
                m_pend = 1'b0;
            end
            case (ph)
                P_IDLE: if (start_empty_n) begin
                    m_rem   = longint'(num_items);
                    m_base  = base_addr;
                    m_items = 0;
                    ph      = (num_items != 0) ? P_RUN : P_FLUSH;
                end
                P_RUN:   if (m_rem == 0) ph = P_FLUSH;
                P_FLUSH: if (!pend_b && out_b == 0) ph = P_DONE;
                default: ph = P_IDLE;
            endcase
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < budget) begin
            cycle();
            i++;
        end
        check(tag, done_cnt != d0, 1'b1);
    endtask

    task automatic wait_acc(input string tag, input int target, input int budget);
        int i;
        i = 0;
        while (acc_log.size() < target && i < budget) begin
            cycle();
            i++;
        end
        check(tag, acc_log.size() >= target, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b;
        logic [31:0] a0;
        logic [31:0] d0w;
        logic [31:0] exp_list[$];
        int          d0;
        int          p0;
        int          n;

        reset = 1'b1;
        run_cycles(2);
        reset = 1'b0;
        run_cycles(2);
        #1;
        check("rst_idle", idle, 1'b1);
        check("rst_items", items_written, 0);
        check("rst_wr_addr", wr_addr, 0);

        // Single run of four writes.
        acc_log.delete();
        start_q.push_back('{32'd4, 32'h1000});
        for (int i = 0; i < 4; i++) upd_q.push_back({32'(i), 32'(5 + i)});
        d0 = done_cnt;
        wait_done("t1_done", 100);
        run_cycles(2);
        #1;
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_items", items_written, 4);
        check("t1_nwrites", acc_log.size(), 4);
        for (int i = 0; i < acc_log.size(); i++) begin
            check("t1_addr", acc_log[i].addr, 32'h1000 + 32'(4 * i));
            check("t1_consecutive", acc_log[i].c - acc_log[0].c, i);
        end

        // Backpressure: five cycles with wr_ready low.
        acc_log.delete();
        exp_list.delete();
        b = $urandom & 32'hFFFF_FFF0;
        start_q.push_back('{32'd8, b});
        for (int i = 0; i < 8; i++) begin
            logic [31:0] vid;
            vid = $urandom_range(0, 4095);
            upd_q.push_back({vid, 32'($urandom)});
            exp_list.push_back(exp_addr(b, vid));
        end
        wait_acc("t2_pre", 2, 50);
        ready_mode = 2;
        #1;
        a0  = wr_addr;
        d0w = wr_data;
        check("t2_held_valid", wr_valid, 1'b1);
        p0 = n_pops;
        run_cycles(5);
        #1;
        check("t2_addr_stable", wr_addr, a0);
        check("t2_data_stable", wr_data, d0w);
        check("t2_no_pops", n_pops - p0, 0);
        ready_mode = 0;
        wait_done("t2_done", 200);
        check("t2_nwrites", acc_log.size(), 8);
        for (int i = 0; i < acc_log.size() && i < exp_list.size(); i++)
            check("t2_addr", acc_log[i].addr, exp_list[i]);

        // Outstanding limit with responses withheld.
        acc_log.delete();
        resp_hold = 1'b1;
        resp_release = 0;
        start_q.push_back('{32'd20, 32'h4000});
        for (int i = 0; i < 20; i++) upd_q.push_back({32'(i), 32'(i * 3)});
        run_cycles(60);
        check("t3_limit", acc_log.size(), MAX_OUT);
        check("t3_fifo_left", upd_q.size(), 4);
        resp_release = 1;
        run_cycles(15);
        check("t3_one_more", acc_log.size(), MAX_OUT + 1);
        resp_hold = 1'b0;
        wait_done("t3_done", 300);
        check("t3_nwrites", acc_log.size(), 20);

        // Zero items.
        acc_log.delete();
        upd_q.push_back({32'd9, 32'd9});
        start_q.push_back('{32'd0, 32'h1234});
        wait_done("t4_done", 20);
        check("t4_latency", done_cyc - start_pop_cyc, 2);
        check("t4_no_writes", acc_log.size(), 0);
        check("t4_no_pop", upd_q.size(), 1);
        upd_q.delete();

        // Address wrap.
        acc_log.delete();
        start_q.push_back('{32'd1, 32'hFFFF_FFFC});
        upd_q.push_back({32'd1, 32'h55});
        wait_done("t5_done", 50);
        #1;
        check("t5_nwrites", acc_log.size(), 1);
        if (acc_log.size() > 0) check("t5_wrap_addr", acc_log[0].addr, 32'h0);
        check("t5_data", wr_data, 32'h55);

        // Reset mid-run, late responses, then a normal run.
        acc_log.delete();
        resp_delay = 6;
        start_q.push_back('{32'd6, 32'h2000});
        for (int i = 0; i < 6; i++) upd_q.push_back({32'(i), 32'(100 + i)});
        wait_acc("t6_pre", 2, 50);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        upd_q.delete();
        start_q.delete();
        #1;
        check("t6_idle", idle, 1'b1);
        check("t6_wr_valid", wr_valid, 1'b0);
        run_cycles(12);
        check("t6_late_drained", resp_q.size(), 0);
        acc_log.delete();
        resp_hold = 1'b1;
        resp_release = 0;
        start_q.push_back('{32'd20, 32'h3000});
        for (int i = 0; i < 20; i++) upd_q.push_back({32'(i), 32'(i)});
        run_cycles(60);
        check("t6_limit", acc_log.size(), MAX_OUT);
        resp_hold = 1'b0;
        wait_done("t6_done", 300);
        #1;
        check("t6_items", items_written, 20);

        // Randomized runs.
        ready_mode = 1;
        upd_gaps = 1'b1;
        stray_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            acc_log.delete();
            n = $urandom_range(0, 25);
            resp_delay = $urandom_range(1, 8);
            start_q.push_back('{32'(n), 32'($urandom)});
            for (int i = 0; i < n; i++) upd_q.push_back({32'($urandom), 32'($urandom)});
            wait_done("t7_done", 3000);
            #1;
            check("t7_items", items_written, n);
            check("t7_nwrites", acc_log.size(), n);
        end
        ready_mode = 0;
        upd_gaps = 1'b0;
        stray_en = 1'b0;
        run_cycles(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/kcore_write_back.md
# kcore_write_back

Write-back stage of the k-core kernel. It consumes one start token per invocation from the upstream start FIFO and then drains exactly `num_items` (vertex id, core value) updates from the update FIFO. Each update becomes one word write to external memory over a valid/ready request channel. The block signals completion only after every write response has returned.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of vertex id and core value fields, and of `wr_data`.
- `ADDR_WIDTH`, 32: byte-address width of the memory port.
- `CNT_WIDTH`, 32: width of the item count and counters.
- `MAX_OUTSTANDING`, 16: maximum number of accepted writes awaiting a response (power of two, at least 2).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `start_empty_n`  in  1  start FIFO holds a token.
- `start_read`  out  1  pop the start token.
- `num_items`  in  CNT_WIDTH  update count; sampled on the start pop.
- `base_addr`  in  ADDR_WIDTH  core-array byte base; sampled on the start pop.
- `upd_empty_n`  in  1  update FIFO non-empty.
- `upd_read`  out  1  pop one update.
- `upd_dout`  in  2*DATA_WIDTH  {vid[2W-1:W], core[W-1:0]}.
- `wr_valid`  out  1  write request valid.
- `wr_ready`  in  1  memory accepts the request.
- `wr_addr`  out  ADDR_WIDTH  write byte address.
- `wr_data`  out  DATA_WIDTH  write data.
- `wr_resp_valid`  in  1  one write completed; always accepted.
- `idle`  out  1  block is in IDLE.
- `done`  out  1  one-cycle completion pulse.
- `items_written`  out  CNT_WIDTH  writes accepted in the current or last run.

## Operation
States:
- IDLE
  - `start_read = start_empty_n` (combinational).
  - On a pop: latch `num_items` into `remaining` and `base_addr`; clear `items_written`.
  - If `num_items`≠0 go to RUN, else go to FLUSH.
- RUN
  - `upd_read = upd_empty_n & (remaining≠0) & (!wr_valid | wr_ready) & (outstanding + wr_valid < MAX_OUTSTANDING)`.
  - On a pop:
    - `wr_addr <= base + (vid << 2)`, truncated modulo 2^ADDR_WIDTH.
    - `wr_data <= core`.
    - `wr_valid <= 1`.
    - `remaining` decrements.
  - When `remaining` reaches 0 go to FLUSH.
- FLUSH
  - No pops.
  - Wait for `wr_valid`=0 and `outstanding`=0, then go to DONE.
- DONE
  - `done`=1 for exactly one cycle, then go to IDLE.

Request channel:
- `wr_valid` stays high, with `wr_addr`/`wr_data` stable, until `wr_ready`.
- It clears on acceptance unless a new pop occurs in the same cycle, in which case it stays high with the new address and data.

Counters:
- `outstanding` increments on `wr_valid & wr_ready`, decrements on `wr_resp_valid`, and is unchanged when both occur.
- It saturates at 0: a stray response after reset is ignored.
- `items_written` increments on each accepted request. It holds its value after DONE until the next start pop.

Start token handling:
- Tokens are never popped outside IDLE.
- A token present during DONE is popped on the following IDLE cycle.

Reset:
- Returns the block to IDLE and clears all counters and `wr_valid`.
- Applies mid-run as well; in-flight data is dropped.

## Timing
Reset values:
- `start_read`=`start_empty_n` (because reset leaves the block in IDLE).
- `upd_read`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0.
- `idle`=1, `done`=0, `items_written`=0.

Latencies:
- Start pop at cycle t puts the block in RUN at t+1.
- An update pop at cycle t gives `wr_valid` at t+1.
- Throughput is one write per cycle while `wr_ready`=1, the FIFO is non-empty and the outstanding limit is not reached.

Completion:
- `done` asserts the cycle after the first FLUSH cycle in which `wr_valid`=0 and `outstanding`=0.
- `num_items`=0: start pop at t, `done` at t+2, `idle` at t+3.

## Test plan
- Single run: `num_items`=4, `base_addr`=0x1000, vids 0..3 with cores 5,6,7,8, `wr_ready`=1, responses 2 cycles after acceptance. Expect:
  - writes to 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles;
  - one `done` pulse after the 4th response;
  - `items_written`=4.
- Backpressure: hold `wr_ready`=0 for 5 cycles with data queued. Expect `wr_addr`/`wr_data` stable, `upd_read`=0 throughout, and no lost or duplicated writes.
- Outstanding limit: `MAX_OUTSTANDING`=16, withhold responses, `num_items`=20. Expect exactly 16 writes accepted, then the stall; releasing one response allows one more write.
- Zero items: start token with `num_items`=0. Expect no `upd_read`, no `wr_valid`, and `done` 2 cycles after the start pop.
- Address wrap: `base_addr`=0xFFFFFFFC, vid=1. Expect `wr_addr`=0x00000000.
- Reset mid-run: assert `reset` after 2 of 6 writes. Expect:
  - `idle`=1 and `wr_valid`=0 next cycle;
  - late responses ignored (no underflow);
  - a new start token runs normally.
